// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: mode encodings,
// BCD digit limits and the displayed-time bundle.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_LAP  = 2'b10
  } mode_e;

  localparam int unsigned SEC_ONES_N = 10;
  localparam int unsigned SEC_TENS_N = 6;
  localparam int unsigned MIN_ONES_N = 10;
  localparam int unsigned MIN_TENS_N = 6;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // Mode 11 falls through to stop.
  function automatic logic is_running(
    input logic [1:0] m
  );
    return (m == MODE_RUN) || (m == MODE_LAP);
  endfunction

  function automatic logic is_lap(
    input logic [1:0] m
  );
    return m == MODE_LAP;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One mod-N BCD digit with enable, clear,
// ripple carry-in and combinational carry-out.
module bcd_digit
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned N = SEC_ONES_N
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_n,
  input  logic       en,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  localparam logic [3:0] LAST = 4'(N - 1);

  logic at_last;

  assign at_last = (q == LAST);
  assign cout    = cin & at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!clr_n) begin
      q <= '0;
    end else if (en && cin) begin
      q <= at_last ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch datapath: prescaler, 4-digit BCD
// mm:ss counter and a lap-freezable display.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        clr_n,
  output logic        tick,
  output logic        wrap,
  output logic        running,
  output logic        lapped,
  output logic [15:0] disp_bcd
);

  localparam int unsigned PW =
    (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic          expire;
  logic [3:0]    carry;
  bcd_time_t     live;
  bcd_time_t     disp_q;

  assign running = is_running(mode);
  assign lapped  = is_lap(mode);

  // Counter advances on the same edge that raises tick.
  assign expire = running && (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (!clr_n) begin
      pre <= '0;
    end else if (running) begin
      pre <= expire ? '0 : pre + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (!clr_n) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= expire;
      wrap <= expire && carry[3];
    end
  end

  bcd_digit #(.N(SEC_ONES_N)) u_sec_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (clr_n),
    .en    (expire),
    .cin   (1'b1),
    .q     (live.sec_ones),
    .cout  (carry[0])
  );

  bcd_digit #(.N(SEC_TENS_N)) u_sec_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (clr_n),
    .en    (expire),
    .cin   (carry[0]),
    .q     (live.sec_tens),
    .cout  (carry[1])
  );

  bcd_digit #(.N(MIN_ONES_N)) u_min_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (clr_n),
    .en    (expire),
    .cin   (carry[1]),
    .q     (live.min_ones),
    .cout  (carry[2])
  );

  bcd_digit #(.N(MIN_TENS_N)) u_min_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (clr_n),
    .en    (expire),
    .cin   (carry[2]),
    .q     (live.min_tens),
    .cout  (carry[3])
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (!clr_n) begin
      disp_q <= '0;
    end else if (!lapped) begin
      disp_q <= live;
    end
  end

  assign disp_bcd = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: directed scenarios plus random
// mode/clear/reset traffic against a seconds model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        clr_n;
  logic        tick;
  logic        wrap;
  logic        running;
  logic        lapped;
  logic [15:0] disp_bcd;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .clr_n    (clr_n),
    .tick     (tick),
    .wrap     (wrap),
    .running  (running),
    .lapped   (lapped),
    .disp_bcd (disp_bcd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_pre  = 0;
  int m_secs = 0;
  int m_disp = 0;
  bit m_tick = 0;
  bit m_wrap = 0;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h expected %h",
                 tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm;
    int ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Stopwatch behaviour in whole seconds.
  task automatic model_edge();
    bit run_now;
    bit exp_now;
    if (!rst_n || !clr_n) begin
      m_pre  = 0;
      m_secs = 0;
      m_disp = 0;
      m_tick = 0;
      m_wrap = 0;
    end else begin
      run_now = (mode == 2'b01) || (mode == 2'b10);
      exp_now = run_now && (m_pre == DIV - 1);
      if (mode != 2'b10) m_disp = m_secs;
      if (run_now) m_pre = (m_pre + 1) % DIV;
      m_tick = exp_now;
      m_wrap = exp_now && (m_secs == 3599);
      if (exp_now) m_secs = (m_secs + 1) % 3600;
    end
  endtask

  task automatic cyc();
    bit exp_run;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_run = (mode == 2'b01) || (mode == 2'b10);
    check("tick", 16'(tick), 16'(m_tick));
    check("wrap", 16'(wrap), 16'(m_wrap));
    check("disp", disp_bcd, to_bcd(m_disp));
    check("running", 16'(running), 16'(exp_run));
    check("lapped", 16'(lapped), 16'(mode == 2'b10));
  endtask

  task automatic do_clear();
    clr_n = 1'b0;
    cyc();
    clr_n = 1'b1;
  endtask

  initial begin
    int last;
    int nt;
    int nw;
    int k;
    bit seen_top;
    bit seq_ok;
    logic [15:0] held;

    rst_n = 1'b0;
    clr_n = 1'b1;
    mode  = 2'b01;
    @(negedge clk);
    cyc();
    cyc();
    check("rst_disp", disp_bcd, 16'h0000);
    check("rst_tick", 16'(tick), 16'h0);
    check("rst_wrap", 16'(wrap), 16'h0);
    rst_n = 1'b1;

    last = -1;
    nt   = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (tick) begin
        if (last < 0) check("first_tick", 16'(i), 16'd4);
        else check("tick_gap", 16'(i - last), 16'd4);
        last = i;
        nt++;
      end
    end
    check("tick_cnt", 16'(nt), 16'd10);
    cyc();
    check("run_disp", disp_bcd, 16'h0010);

    do_clear();
    k = 0;
    while (k < 200 && disp_bcd !== 16'h0005) begin
      cyc();
      k++;
    end
    check("lap_reach", disp_bcd, 16'h0005);
    mode = 2'b10;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("lap_hold", disp_bcd, 16'h0005);
      check("lap_flag", 16'(lapped), 16'h1);
    end
    mode = 2'b01;
    cyc();
    check("lap_resume", disp_bcd, 16'h0010);

    do_clear();
    nw       = 0;
    seen_top = 0;
    seq_ok   = 0;
    for (int i = 0; i < 3600 * DIV + 4; i++) begin
      cyc();
      if (wrap) nw++;
      if (disp_bcd == 16'h5959) seen_top = 1;
      if (seen_top && disp_bcd == 16'h0000) seq_ok = 1;
    end
    check("wrap_cnt", 16'(nw), 16'd1);
    check("wrap_seq", 16'(seq_ok), 16'd1);

    do_clear();
    k = 0;
    while (k < 2000 &&
           !(m_secs == 82 && m_pre == DIV - 1)) begin
      cyc();
      k++;
    end
    check("clr_reach", 16'(m_secs), 16'd82);
    clr_n = 1'b0;
    cyc();
    clr_n = 1'b1;
    check("clr_disp", disp_bcd, 16'h0000);
    check("clr_tick", 16'(tick), 16'h0);
    check("clr_wrap", 16'(wrap), 16'h0);
    cyc();
    check("clr_live", disp_bcd, 16'h0000);

    for (int i = 0; i < 30; i++) cyc();
    mode = 2'b11;
    held = to_bcd(m_secs);
    nt   = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick) nt++;
      check("hold11_disp", disp_bcd, held);
    end
    check("hold11_tick", 16'(nt), 16'd0);
    check("hold11_run", 16'(running), 16'h0);

    mode = 2'b01;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 99);
        mode = (k < 50) ? 2'b01 :
               (k < 70) ? 2'b10 :
               (k < 85) ? 2'b00 : 2'b11;
      end
      clr_n = ($urandom_range(0, 149) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
